// File: rtl/control_pipeline.sv
// control_pipeline: control-side pipeline state between decode and writeback.
// Carries the decoded control bundle through the EX, MEM and WB stage
// registers, detects load-use hazards and taken-branch redirects, and
// produces the stall, flush and operand-forwarding selects for the datapath.
module control_pipeline #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALU_OP_WIDTH   = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  // decode-stage bundle
  input  logic                      decodeValid,
  input  logic                      decodeBranchEnable,
  input  logic                      decodeMemoryReadEnable,
  input  logic                      decodeMemoryWriteEnable,
  input  logic                      decodeRegisterWriteEnable,
  input  logic                      decodeImmediateEnable,
  input  logic                      decodeMemoryOrAlu,
  input  logic [ALU_OP_WIDTH-1:0]   decodeAluOperation,
  input  logic [REG_ADDR_WIDTH-1:0] decodeRd,
  input  logic [REG_ADDR_WIDTH-1:0] decodeRs1,
  input  logic [REG_ADDR_WIDTH-1:0] decodeRs2,
  input  logic                      decodeUsesRs1,
  input  logic                      decodeUsesRs2,
  // pipeline events
  input  logic                      executeBranchTaken,
  input  logic                      memoryStall,
  // EX stage
  output logic                      executeValid,
  output logic                      executeBranchEnable,
  output logic                      executeMemoryReadEnable,
  output logic                      executeMemoryWriteEnable,
  output logic                      executeRegisterWriteEnable,
  output logic                      executeImmediateEnable,
  output logic                      executeMemoryOrAlu,
  output logic [ALU_OP_WIDTH-1:0]   executeAluOperation,
  output logic [REG_ADDR_WIDTH-1:0] executeRd,
  // MEM stage
  output logic                      memValid,
  output logic                      memMemoryReadEnable,
  output logic                      memMemoryWriteEnable,
  output logic                      memRegisterWriteEnable,
  output logic                      memMemoryOrAlu,
  output logic [REG_ADDR_WIDTH-1:0] memRd,
  // WB stage
  output logic                      wbValid,
  output logic                      wbRegisterWriteEnable,
  output logic                      wbMemoryOrAlu,
  output logic [REG_ADDR_WIDTH-1:0] wbRd,
  // hazard / forwarding controls
  output logic [1:0]                forwardA,
  output logic [1:0]                forwardB,
  output logic                      stallFetch,
  output logic                      stallDecode,
  output logic                      flushDecode
);

  // Stage register layouts. A bubble is simply the all-zero value of each.
  typedef struct packed {
    logic                      valid;
    logic                      branch;
    logic                      mem_read;
    logic                      mem_write;
    logic                      reg_write;
    logic                      imm;
    logic                      mem_or_alu;
    logic [ALU_OP_WIDTH-1:0]   alu_op;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
  } ex_stage_t;

  typedef struct packed {
    logic                      valid;
    logic                      mem_read;
    logic                      mem_write;
    logic                      reg_write;
    logic                      mem_or_alu;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } mem_stage_t;

  typedef struct packed {
    logic                      valid;
    logic                      reg_write;
    logic                      mem_or_alu;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } wb_stage_t;

  ex_stage_t  ex_reg,  ex_next;
  mem_stage_t mem_reg, mem_next;
  wb_stage_t  wb_reg,  wb_next;
  ex_stage_t  decode_capture;

  logic       branch_redirect;
  logic       rs_match;
  logic       load_use;
  logic       ex_bubble;
  logic [1:0][1:0] fwd_sel;

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
  assign branch_redirect = ex_reg.valid && executeBranchTaken;

  assign rs_match = (decodeUsesRs1 && (decodeRs1 == ex_reg.rd)) ||
                    (decodeUsesRs2 && (decodeRs2 == ex_reg.rd));

  // A load to x0 never creates a dependency, so rd == 0 bypasses the check.
  assign load_use = ex_reg.valid && ex_reg.mem_read && (ex_reg.rd != '0) &&
                    decodeValid && rs_match;

  // Either event replaces the instruction entering EX with a bubble.
  assign ex_bubble = branch_redirect || load_use;

  // A redirect squashes the decode slot, so it overrides any load-use stall.
  // While reset is held every control output reads as 0.
  assign stallFetch  = !reset && (memoryStall || (!branch_redirect && load_use));
  assign stallDecode = !reset && (memoryStall || (!branch_redirect && load_use));
  assign flushDecode = !reset && !memoryStall && branch_redirect;

  // --------------------------------------------------------------------------
  // Operand forwarding, one unit per EX source operand
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic [REG_ADDR_WIDTH-1:0] src;
      logic                      hit_mem;
      logic                      hit_wb;

      assign src     = (gi == 0) ? ex_reg.rs1 : ex_reg.rs2;
      assign hit_mem = mem_reg.valid && mem_reg.reg_write &&
                       (mem_reg.rd != '0) && (mem_reg.rd == src);
      assign hit_wb  = wb_reg.valid && wb_reg.reg_write &&
                       (wb_reg.rd != '0) && (wb_reg.rd == src);
      // The younger MEM result shadows the older WB result.
      assign fwd_sel[gi] = hit_mem ? 2'b10 : (hit_wb ? 2'b01 : 2'b00);
    end
  endgenerate

  assign forwardA = fwd_sel[0];
  assign forwardB = fwd_sel[1];

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------

  // Build the EX entry from decode; an empty slot becomes a clean bubble and
  // unused source indices read as 0 so they can never match a forward.
  always_comb begin
    decode_capture = '0;
    if (decodeValid) begin
      decode_capture.valid      = 1'b1;
      decode_capture.branch     = decodeBranchEnable;
      decode_capture.mem_read   = decodeMemoryReadEnable;
      decode_capture.mem_write  = decodeMemoryWriteEnable;
      decode_capture.reg_write  = decodeRegisterWriteEnable;
      decode_capture.imm        = decodeImmediateEnable;
      decode_capture.mem_or_alu = decodeMemoryOrAlu;
      decode_capture.alu_op     = decodeAluOperation;
      decode_capture.rd         = decodeRd;
    end
    decode_capture.rs1 = decodeUsesRs1 ? decodeRs1 : '0;
    decode_capture.rs2 = decodeUsesRs2 ? decodeRs2 : '0;
  end

  // Advance, bubble or hold each stage according to the stall/redirect state.
  always_comb begin
    ex_next  = ex_reg;
    mem_next = mem_reg;
    wb_next  = wb_reg;
    if (!memoryStall) begin
      mem_next.valid      = ex_reg.valid;
      mem_next.mem_read   = ex_reg.mem_read;
      mem_next.mem_write  = ex_reg.mem_write;
      mem_next.reg_write  = ex_reg.reg_write;
      mem_next.mem_or_alu = ex_reg.mem_or_alu;
      mem_next.rd         = ex_reg.rd;

      wb_next.valid       = mem_reg.valid;
      wb_next.reg_write   = mem_reg.reg_write;
      wb_next.mem_or_alu  = mem_reg.mem_or_alu;
      wb_next.rd          = mem_reg.rd;

      if (ex_bubble) begin
        ex_next = '0;
      end else begin
        ex_next = decode_capture;
      end
    end
  end

  // Stage registers; reset clears every stage to a bubble immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_reg  <= '0;
      mem_reg <= '0;
      wb_reg  <= '0;
    end else begin
      ex_reg  <= ex_next;
      mem_reg <= mem_next;
      wb_reg  <= wb_next;
    end
  end

  // --------------------------------------------------------------------------
  // Output mapping
  // --------------------------------------------------------------------------
  assign executeValid               = ex_reg.valid;
  assign executeBranchEnable        = ex_reg.branch;
  assign executeMemoryReadEnable    = ex_reg.mem_read;
  assign executeMemoryWriteEnable   = ex_reg.mem_write;
  assign executeRegisterWriteEnable = ex_reg.reg_write;
  assign executeImmediateEnable     = ex_reg.imm;
  assign executeMemoryOrAlu         = ex_reg.mem_or_alu;
  assign executeAluOperation        = ex_reg.alu_op;
  assign executeRd                  = ex_reg.rd;

  assign memValid                   = mem_reg.valid;
  assign memMemoryReadEnable        = mem_reg.mem_read;
  assign memMemoryWriteEnable       = mem_reg.mem_write;
  assign memRegisterWriteEnable     = mem_reg.reg_write;
  assign memMemoryOrAlu             = mem_reg.mem_or_alu;
  assign memRd                      = mem_reg.rd;

  assign wbValid                    = wb_reg.valid;
  assign wbRegisterWriteEnable      = wb_reg.reg_write;
  assign wbMemoryOrAlu              = wb_reg.mem_or_alu;
  assign wbRd                       = wb_reg.rd;

endmodule

// File: tb/tb_control_pipeline.sv
module tb_control_pipeline;

    localparam int RW = 5;
    localparam int AW = 2;

    localparam int F_EXV = 0,  F_EXBR = 1,  F_EXMR = 2,  F_EXMW = 3,  F_EXRW = 4;
    localparam int F_EXIMM = 5, F_EXMOA = 6, F_EXALU = 7, F_EXRD = 8;
    localparam int F_MEMV = 9, F_MEMMR = 10, F_MEMMW = 11, F_MEMRW = 12;
    localparam int F_MEMMOA = 13, F_MEMRD = 14;
    localparam int F_WBV = 15, F_WBRW = 16, F_WBMOA = 17, F_WBRD = 18;
    localparam int F_FA = 19, F_FB = 20, F_SF = 21, F_SD = 22, F_FL = 23;
    localparam int NF = 24;

    logic clock;
    logic reset;
    logic decodeValid, decodeBranchEnable, decodeMemoryReadEnable;
    logic decodeMemoryWriteEnable, decodeRegisterWriteEnable;
    logic decodeImmediateEnable, decodeMemoryOrAlu;
    logic [AW-1:0] decodeAluOperation;
    logic [RW-1:0] decodeRd, decodeRs1, decodeRs2;
    logic decodeUsesRs1, decodeUsesRs2;
    logic executeBranchTaken, memoryStall;
    logic executeValid, executeBranchEnable, executeMemoryReadEnable;
    logic executeMemoryWriteEnable, executeRegisterWriteEnable;
    logic executeImmediateEnable, executeMemoryOrAlu;
    logic [AW-1:0] executeAluOperation;
    logic [RW-1:0] executeRd;
    logic memValid, memMemoryReadEnable, memMemoryWriteEnable;
    logic memRegisterWriteEnable, memMemoryOrAlu;
    logic [RW-1:0] memRd;
    logic wbValid, wbRegisterWriteEnable, wbMemoryOrAlu;
    logic [RW-1:0] wbRd;
    logic [1:0] forwardA, forwardB;
    logic stallFetch, stallDecode, flushDecode;

    control_pipeline #(.REG_ADDR_WIDTH(RW), .ALU_OP_WIDTH(AW)) dut (
        .clock(clock), .reset(reset),
        .decodeValid(decodeValid), .decodeBranchEnable(decodeBranchEnable),
        .decodeMemoryReadEnable(decodeMemoryReadEnable),
        .decodeMemoryWriteEnable(decodeMemoryWriteEnable),
        .decodeRegisterWriteEnable(decodeRegisterWriteEnable),
        .decodeImmediateEnable(decodeImmediateEnable),
        .decodeMemoryOrAlu(decodeMemoryOrAlu), .decodeAluOperation(decodeAluOperation),
        .decodeRd(decodeRd), .decodeRs1(decodeRs1), .decodeRs2(decodeRs2),
        .decodeUsesRs1(decodeUsesRs1), .decodeUsesRs2(decodeUsesRs2),
        .executeBranchTaken(executeBranchTaken), .memoryStall(memoryStall),
        .executeValid(executeValid), .executeBranchEnable(executeBranchEnable),
        .executeMemoryReadEnable(executeMemoryReadEnable),
        .executeMemoryWriteEnable(executeMemoryWriteEnable),
        .executeRegisterWriteEnable(executeRegisterWriteEnable),
        .executeImmediateEnable(executeImmediateEnable),
        .executeMemoryOrAlu(executeMemoryOrAlu), .executeAluOperation(executeAluOperation),
        .executeRd(executeRd),
        .memValid(memValid), .memMemoryReadEnable(memMemoryReadEnable),
        .memMemoryWriteEnable(memMemoryWriteEnable),
        .memRegisterWriteEnable(memRegisterWriteEnable),
        .memMemoryOrAlu(memMemoryOrAlu), .memRd(memRd),
        .wbValid(wbValid), .wbRegisterWriteEnable(wbRegisterWriteEnable),
        .wbMemoryOrAlu(wbMemoryOrAlu), .wbRd(wbRd),
        .forwardA(forwardA), .forwardB(forwardB),
        .stallFetch(stallFetch), .stallDecode(stallDecode), .flushDecode(flushDecode)
    );

    typedef struct {
        int cyc;
        int fld;
        int val;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic string field_name(int f);
        case (f)
            F_EXV: return "executeValid";     F_EXBR: return "executeBranchEnable";
            F_EXMR: return "executeMemRead";  F_EXMW: return "executeMemWrite";
            F_EXRW: return "executeRegWrite"; F_EXIMM: return "executeImmediate";
            F_EXMOA: return "executeMemOrAlu"; F_EXALU: return "executeAluOp";
            F_EXRD: return "executeRd";       F_MEMV: return "memValid";
            F_MEMMR: return "memMemRead";     F_MEMMW: return "memMemWrite";
            F_MEMRW: return "memRegWrite";    F_MEMMOA: return "memMemOrAlu";
            F_MEMRD: return "memRd";          F_WBV: return "wbValid";
            F_WBRW: return "wbRegWrite";      F_WBMOA: return "wbMemOrAlu";
            F_WBRD: return "wbRd";            F_FA: return "forwardA";
            F_FB: return "forwardB";          F_SF: return "stallFetch";
            F_SD: return "stallDecode";       F_FL: return "flushDecode";
            default: return "unknown";
        endcase
    endfunction

    function automatic logic [31:0] get_field(int f);
        case (f)
            F_EXV: return 32'(executeValid);        F_EXBR: return 32'(executeBranchEnable);
            F_EXMR: return 32'(executeMemoryReadEnable);
            F_EXMW: return 32'(executeMemoryWriteEnable);
            F_EXRW: return 32'(executeRegisterWriteEnable);
            F_EXIMM: return 32'(executeImmediateEnable);
            F_EXMOA: return 32'(executeMemoryOrAlu); F_EXALU: return 32'(executeAluOperation);
            F_EXRD: return 32'(executeRd);           F_MEMV: return 32'(memValid);
            F_MEMMR: return 32'(memMemoryReadEnable); F_MEMMW: return 32'(memMemoryWriteEnable);
            F_MEMRW: return 32'(memRegisterWriteEnable); F_MEMMOA: return 32'(memMemoryOrAlu);
            F_MEMRD: return 32'(memRd);              F_WBV: return 32'(wbValid);
            F_WBRW: return 32'(wbRegisterWriteEnable); F_WBMOA: return 32'(wbMemoryOrAlu);
            F_WBRD: return 32'(wbRd);                F_FA: return 32'(forwardA);
            F_FB: return 32'(forwardB);              F_SF: return 32'(stallFetch);
            F_SD: return 32'(stallDecode);           F_FL: return 32'(flushDecode);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(negedge clock) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                logic [31:0] act;
                act = get_field(sb[i].fld);
                n_checks++;
                if (act !== 32'(sb[i].val)) begin
                    n_fail++;
                    $display("FAIL c%0d %s: got %0h expected %0h", cyc,
                             field_name(sb[i].fld), act, sb[i].val);
                end else begin
                    $display("c%0d %s = %0h ok", cyc, field_name(sb[i].fld), act);
                end
                sb.delete(i);
            end
        end
    end

    task automatic chk(int f, int v);
        exp_t e;
        e.cyc = cyc;
        e.fld = f;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk_all_zero();
        for (int f = 0; f < NF; f++) chk(f, 0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic dec(input logic v, input logic br, input logic mr, input logic mw,
                       input logic rw, input logic imm, input logic moa,
                       input logic [AW-1:0] alu, input logic [RW-1:0] rd,
                       input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                       input logic u1, input logic u2);
        decodeValid = v;               decodeBranchEnable = br;
        decodeMemoryReadEnable = mr;   decodeMemoryWriteEnable = mw;
        decodeRegisterWriteEnable = rw; decodeImmediateEnable = imm;
        decodeMemoryOrAlu = moa;       decodeAluOperation = alu;
        decodeRd = rd; decodeRs1 = rs1; decodeRs2 = rs2;
        decodeUsesRs1 = u1; decodeUsesRs2 = u2;
    endtask

    task automatic idle();
        dec(0, 0, 0, 0, 0, 0, 0, 2'd0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        memoryStall = 1'b0;
        executeBranchTaken = 1'b0;
        idle();

        step();
        step(); chk_all_zero();
        step(); reset = 1'b0;

        dec(1, 0, 0, 0, 1, 0, 0, 2'd2, 5'd3, 5'd1, 5'd2, 1, 1);
        chk(F_SF, 0); chk(F_FL, 0);
        step();
        dec(1, 0, 0, 0, 1, 1, 0, 2'd0, 5'd4, 5'd3, 5'd9, 1, 0);
        chk(F_EXV, 1); chk(F_EXRW, 1); chk(F_EXALU, 2); chk(F_EXRD, 3); chk(F_SF, 0);
        step();
        dec(1, 0, 0, 1, 0, 1, 0, 2'd0, 5'd0, 5'd4, 5'd3, 1, 1);
        chk(F_MEMV, 1); chk(F_MEMRW, 1); chk(F_MEMRD, 3); chk(F_EXRD, 4);
        chk(F_EXIMM, 1); chk(F_FA, 2); chk(F_FB, 0); chk(F_SF, 0);
        step();
        idle();
        chk(F_WBV, 1); chk(F_WBRW, 1); chk(F_WBRD, 3); chk(F_EXMW, 1);
        chk(F_EXRW, 0); chk(F_FA, 2); chk(F_FB, 1);
        step();

        dec(1, 0, 1, 0, 1, 1, 1, 2'd0, 5'd5, 5'd1, 5'd0, 1, 0);
        chk(F_EXV, 0); chk(F_MEMV, 1); chk(F_MEMMW, 1); chk(F_WBRD, 4);
        step();
        dec(1, 0, 0, 0, 1, 0, 0, 2'd2, 5'd6, 5'd5, 5'd2, 1, 1);
        chk(F_EXMR, 1); chk(F_EXRD, 5); chk(F_SF, 1); chk(F_SD, 1); chk(F_FL, 0);
        step();
        chk(F_EXV, 0); chk(F_MEMMR, 1); chk(F_MEMRD, 5); chk(F_SF, 0); chk(F_SD, 0);
        step();

        dec(1, 0, 1, 0, 1, 1, 1, 2'd0, 5'd0, 5'd1, 5'd0, 1, 0);
        chk(F_EXV, 1); chk(F_EXRD, 6); chk(F_FA, 1); chk(F_FB, 0);
        chk(F_WBRD, 5); chk(F_MEMV, 0);
        step();
        dec(1, 0, 0, 0, 1, 0, 0, 2'd2, 5'd7, 5'd0, 5'd0, 1, 0);
        chk(F_EXMR, 1); chk(F_EXRD, 0); chk(F_SF, 0); chk(F_SD, 0);
        step();

        dec(1, 0, 0, 0, 1, 0, 0, 2'd2, 5'd7, 5'd1, 5'd0, 1, 0);
        chk(F_EXV, 1); chk(F_EXRD, 7); chk(F_FA, 0);
        step();
        dec(1, 0, 0, 0, 1, 0, 0, 2'd2, 5'd7, 5'd1, 5'd0, 1, 0);
        step();
        dec(1, 0, 0, 0, 1, 0, 0, 2'd2, 5'd8, 5'd0, 5'd7, 0, 1);
        step();
        dec(1, 0, 0, 0, 1, 0, 0, 2'd2, 5'd9, 5'd0, 5'd7, 0, 1);
        chk(F_FB, 2); chk(F_FA, 0); chk(F_MEMRD, 7); chk(F_WBRD, 7);
        step();

        dec(1, 0, 1, 0, 1, 1, 1, 2'd0, 5'd10, 5'd1, 5'd0, 1, 0);
        chk(F_FB, 1); chk(F_MEMRD, 8);
        step();
        dec(1, 0, 0, 0, 1, 0, 0, 2'd2, 5'd11, 5'd10, 5'd0, 1, 0);
        executeBranchTaken = 1'b1;
        chk(F_FL, 1); chk(F_SF, 0); chk(F_SD, 0); chk(F_EXMR, 1);
        step();
        executeBranchTaken = 1'b0;
        dec(1, 0, 0, 0, 1, 0, 0, 2'd1, 5'd12, 5'd0, 5'd0, 0, 0);
        chk(F_EXV, 0); chk(F_FL, 0); chk(F_MEMRD, 10); chk(F_MEMMR, 1);
        step();

        dec(1, 0, 0, 0, 1, 0, 0, 2'd2, 5'd13, 5'd0, 5'd0, 0, 0);
        chk(F_EXALU, 1); chk(F_EXRD, 12);
        step();
        dec(1, 0, 0, 1, 0, 1, 0, 2'd0, 5'd0, 5'd12, 5'd13, 1, 1);
        chk(F_EXRD, 13);
        step();
        idle();
        memoryStall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk(F_SF, 1); chk(F_SD, 1); chk(F_FL, 0); chk(F_EXV, 1); chk(F_EXMW, 1);
            chk(F_MEMRD, 13); chk(F_WBRD, 12); chk(F_FA, 1); chk(F_FB, 2);
            step();
        end
        chk_all_zero();
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (executeValid !== 1'b0) begin
            n_fail++;
            $display("FAIL async reset: executeValid = %0b", executeValid);
        end else $display("async reset executeValid = 0 ok");
        n_checks++;
        if (memValid !== 1'b0) begin
            n_fail++;
            $display("FAIL async reset: memValid = %0b", memValid);
        end else $display("async reset memValid = 0 ok");
        n_checks++;
        if (wbValid !== 1'b0) begin
            n_fail++;
            $display("FAIL async reset: wbValid = %0b", wbValid);
        end else $display("async reset wbValid = 0 ok");
        n_checks++;
        if (stallFetch !== 1'b0) begin
            n_fail++;
            $display("FAIL async reset: stallFetch = %0b", stallFetch);
        end else $display("async reset stallFetch = 0 ok");
        n_checks++;
        if (flushDecode !== 1'b0) begin
            n_fail++;
            $display("FAIL async reset: flushDecode = %0b", flushDecode);
        end else $display("async reset flushDecode = 0 ok");
        n_checks++;
        if (forwardB !== 2'b00) begin
            n_fail++;
            $display("FAIL async reset: forwardB = %0b", forwardB);
        end else $display("async reset forwardB = 00 ok");
        step();
        reset = 1'b0;
        memoryStall = 1'b0;
        dec(1, 0, 0, 0, 1, 0, 0, 2'd2, 5'd14, 5'd0, 5'd0, 0, 0);
        chk(F_EXV, 0); chk(F_SF, 0);
        step();
        idle();
        chk(F_EXV, 1); chk(F_EXRD, 14); chk(F_EXALU, 2);
        step();
        chk(F_MEMRD, 14); chk(F_EXV, 0);
        step();
        step();
        @(negedge clock);
        #1;
        foreach (sb[i]) begin
            n_checks++;
            n_fail++;
            $display("FAIL c%0d %s: never checked, expected %0h", sb[i].cyc,
                     field_name(sb[i].fld), sb[i].val);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
